// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter
//   Receiving end of the shared 16-bit tri-state data bus. Grants one bus
//   driver at a time (round-robin), holds its drive enable for a DRIVE and a
//   CAPTURE cycle, samples the bus at the end of CAPTURE, then keeps every
//   enable low for TURN cycles before the next grant. Captured words are
//   queued with their source ID for a downstream consumer.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [N_SRC]  per-source request, held until that source's ack
//   drv_en     out  [N_SRC]  registered tri-state enable, one-hot or zero
//   bus        in   [16]     resolved bus value
//   ack        out  [N_SRC]  one-cycle pulse during the capture cycle
//   out_data   out  [16]     FIFO head data (0 while empty)
//   out_src    out  [SW]     FIFO head source ID (0 while empty)
//   out_valid  out           FIFO non-empty
//   out_ready  in            consumer accepts the head
//   fifo_count out  [CW]     FIFO occupancy
//   busy       out           FSM not in IDLE
//
// Output handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and the head
// (out_data/out_src) holds steady while out_valid is high and out_ready low.
module bus_read_arbiter #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TURN       = 1,
  parameter int SW         = $clog2(N_SRC),
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  output logic [N_SRC-1:0]  drv_en,
  input  logic [15:0]       bus,
  output logic [N_SRC-1:0]  ack,
  output logic [15:0]       out_data,
  output logic [SW-1:0]     out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     fifo_count,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TCW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [N_SRC-1:0] ONE_C = {{(N_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_TURN
  } state_t;

  state_t state, state_next;

  logic [SW-1:0]  last_grant;   // also the current grant while a transfer runs
  logic [SW-1:0]  win;
  logic [SW-1:0]  cand;
  logic           found;
  logic           do_grant;
  logic           push;
  logic           pop;
  logic [TCW-1:0] turn_cnt;

  logic [15:0]    mem_data [FIFO_DEPTH];
  logic [SW-1:0]  mem_src  [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Round-robin pick: scan from the source after the last grant, wrapping.
  always_comb begin
    win   = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = SW'((int'(last_grant) + i) % N_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    ack        = '0;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only one transfer is ever in flight, so checking room here is enough.
        if (found && (fifo_count != DEPTH_C)) begin
          do_grant   = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE:   state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        ack        = ONE_C << last_grant;
        push       = 1'b1;
        state_next = ST_TURN;
      end
      ST_TURN: begin
        if (turn_cnt == TCW'(TURN - 1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Grant, drive enables and turnaround counter. drv_en is raised on the
  // grant edge and dropped on the capture edge, so it covers DRIVE+CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SW'(N_SRC - 1);
      drv_en     <= '0;
      turn_cnt   <= '0;
    end else begin
      if (do_grant) begin
        last_grant <= win;
        drv_en     <= ONE_C << win;
      end else if (state == ST_CAPTURE) begin
        drv_en <= '0;
      end
      if (state == ST_TURN) turn_cnt <= turn_cnt + TCW'(1);
      else                  turn_cnt <= '0;
    end
  end

  // Capture FIFO
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus;
      mem_src[wr_ptr]  <= last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Memory is not reset; mask the head so outputs read zero while empty.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_src  = out_valid ? mem_src[rd_ptr]  : '0;

endmodule
